branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_pkg.sv | 38 +++
 rtl/branch_predictor_if.sv | 45 ++++
 rtl/bp_sat_ctr.sv | 23 ++
 rtl/branch_predictor.sv | 146 ++++++++++++++
 tb/tb_branch_predictor.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared definitions for the branch predictor.
// Holds the branch func3 codes, the 2-bit counter encodings, and the helper
// that turns ALU compare flags into a branch outcome.
package branch_pkg;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    // Unsigned compares must use sltu; func3 010/011 are not branches.
    function automatic logic branch_outcome(input logic [2:0] func3,
                                            input logic       eq,
                                            input logic       slt,
                                            input logic       sltu);
        logic taken;
        case (func3)
            BEQ:     taken = eq;
            BNE:     taken = ~eq;
            BLT:     taken = slt;
            BGE:     taken = ~slt;
            BLTU:    taken = sltu;
            BGEU:    taken = ~sltu;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch / resolve / redirect / statistics bundle of the branch predictor.
// master: pipeline side (drives fetch PC and resolve info).
// slave : predictor side (drives prediction, redirect and counters).
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] i_fetch_pc;
    logic            o_pred_taken;
    logic [XLEN-1:0] o_pred_target;

    logic            i_res_valid;
    logic [XLEN-1:0] i_res_pc;
    logic [2:0]      i_res_func3;
    logic            i_res_branch;
    logic            i_res_jal;
    logic            i_res_jalr;
    logic            i_res_eq;
    logic            i_res_slt;
    logic            i_res_sltu;
    logic [XLEN-1:0] i_res_target;
    logic            i_res_pred_taken;
    logic [XLEN-1:0] i_res_pred_target;

    logic            o_redirect;
    logic [XLEN-1:0] o_redirect_pc;
    logic [31:0]     o_stat_branches;
    logic [31:0]     o_stat_mispredicts;

    modport master (
        output i_fetch_pc, i_res_valid, i_res_pc, i_res_func3, i_res_branch,
               i_res_jal, i_res_jalr, i_res_eq, i_res_slt, i_res_sltu,
               i_res_target, i_res_pred_taken, i_res_pred_target,
        input  o_pred_taken, o_pred_target, o_redirect, o_redirect_pc,
               o_stat_branches, o_stat_mispredicts
    );

    modport slave (
        input  i_fetch_pc, i_res_valid, i_res_pc, i_res_func3, i_res_branch,
               i_res_jal, i_res_jalr, i_res_eq, i_res_slt, i_res_sltu,
               i_res_target, i_res_pred_taken, i_res_pred_target,
        output o_pred_taken, o_pred_target, o_redirect, o_redirect_pc,
               o_stat_branches, o_stat_mispredicts
    );

endinterface

// File: rtl/bp_sat_ctr.sv
// 2-bit saturating counter next-state function.
// Ports: ctr (current value), taken (resolved outcome), ctr_next (new value).
module bp_sat_ctr
    import branch_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step toward ST on taken, toward SNT on not-taken, clamping at the ends.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr == ST) ctr_next = ST;
            else           ctr_next = ctr + 2'd1;
        end else begin
            if (ctr == SNT) ctr_next = SNT;
            else            ctr_next = ctr - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor with a direct-mapped branch target buffer.
// Ports: i_clk, i_rst_n (async active-low), bp (slave side of
// branch_predictor_if: fetch prediction, resolve update, registered
// redirect, saturating statistics).
module branch_predictor
    import branch_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter int         BTB_DEPTH = 16,
    parameter logic [1:0] INIT_CTR  = 2'b01
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    branch_predictor_if.slave  bp
);

    localparam int BHT_IDX_W = $clog2(BHT_DEPTH);
    localparam int BTB_IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W     = XLEN - BTB_IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP  = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [31:0]     STAT_MAX = 32'hFFFF_FFFF;

    logic [1:0]      bht_r        [BHT_DEPTH];
    logic [TAG_W-1:0] btb_tag_r   [BTB_DEPTH];
    logic [XLEN-1:0] btb_target_r [BTB_DEPTH];
    logic [BTB_DEPTH-1:0] btb_valid_r;
    logic [BTB_DEPTH-1:0] btb_jump_r;

    logic            redirect_r;
    logic [XLEN-1:0] redirect_pc_r;
    logic [31:0]     stat_br_r;
    logic [31:0]     stat_mis_r;

    logic [BHT_IDX_W-1:0] fetch_bht_idx_s, res_bht_idx_s;
    logic [BTB_IDX_W-1:0] fetch_btb_idx_s, res_btb_idx_s;
    logic [TAG_W-1:0]     fetch_tag_s, res_tag_s;
    logic                 fetch_hit_s;
    logic                 res_taken_s;
    logic                 res_is_cti_s;
    logic                 mispredict_s;
    logic [1:0]           res_ctr_s, res_ctr_next_s;

    assign fetch_bht_idx_s = bp.i_fetch_pc[BHT_IDX_W+1:2];
    assign fetch_btb_idx_s = bp.i_fetch_pc[BTB_IDX_W+1:2];
    assign fetch_tag_s     = bp.i_fetch_pc[XLEN-1:BTB_IDX_W+2];
    assign res_bht_idx_s   = bp.i_res_pc[BHT_IDX_W+1:2];
    assign res_btb_idx_s   = bp.i_res_pc[BTB_IDX_W+1:2];
    assign res_tag_s       = bp.i_res_pc[XLEN-1:BTB_IDX_W+2];

    // Fetch-side lookup; tables are flops so this sees pre-update contents.
    always_comb begin
        fetch_hit_s      = btb_valid_r[fetch_btb_idx_s] &&
                           (btb_tag_r[fetch_btb_idx_s] == fetch_tag_s);
        bp.o_pred_taken  = 1'b0;
        bp.o_pred_target = bp.i_fetch_pc + PC_STEP;
        if (fetch_hit_s && (btb_jump_r[fetch_btb_idx_s] || bht_r[fetch_bht_idx_s][1])) begin
            bp.o_pred_taken  = 1'b1;
            bp.o_pred_target = btb_target_r[fetch_btb_idx_s];
        end else begin
            bp.o_pred_taken  = 1'b0;
        end
    end

    // Resolve-side outcome and mispredict detection.
    always_comb begin
        res_is_cti_s = bp.i_res_branch | bp.i_res_jal | bp.i_res_jalr;
        if (bp.i_res_branch) begin
            res_taken_s = branch_outcome(bp.i_res_func3, bp.i_res_eq,
                                         bp.i_res_slt, bp.i_res_sltu);
        end else begin
            res_taken_s = bp.i_res_jal | bp.i_res_jalr;
        end
        mispredict_s = bp.i_res_valid &&
                       ((res_taken_s != bp.i_res_pred_taken) ||
                        (res_taken_s && (bp.i_res_target != bp.i_res_pred_target)));
    end

    assign res_ctr_s = bht_r[res_bht_idx_s];

    bp_sat_ctr u_sat_ctr (
        .ctr      (res_ctr_s),
        .taken    (res_taken_s),
        .ctr_next (res_ctr_next_s)
    );

    // Direction table: only conditional branches train the counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) bht_r[i] <= INIT_CTR;
        end else if (bp.i_res_valid && bp.i_res_branch) begin
            bht_r[res_bht_idx_s] <= res_ctr_next_s;
        end
    end

    // Target buffer: allocate/overwrite on every taken control transfer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            btb_valid_r <= '0;
            btb_jump_r  <= '0;
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb_tag_r[i]    <= '0;
                btb_target_r[i] <= '0;
            end
        end else if (bp.i_res_valid && res_taken_s) begin
            btb_valid_r[res_btb_idx_s]  <= 1'b1;
            btb_jump_r[res_btb_idx_s]   <= bp.i_res_jal | bp.i_res_jalr;
            btb_tag_r[res_btb_idx_s]    <= res_tag_s;
            btb_target_r[res_btb_idx_s] <= bp.i_res_target;
        end
    end

    // Redirect pulse; the PC holds its last value between mispredicts.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            redirect_r    <= 1'b0;
            redirect_pc_r <= '0;
        end else begin
            redirect_r <= mispredict_s;
            if (mispredict_s) begin
                redirect_pc_r <= res_taken_s ? bp.i_res_target : (bp.i_res_pc + PC_STEP);
            end
        end
    end

    // Saturating event counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_br_r  <= 32'd0;
            stat_mis_r <= 32'd0;
        end else begin
            if (bp.i_res_valid && res_is_cti_s && (stat_br_r != STAT_MAX)) begin
                stat_br_r <= stat_br_r + 32'd1;
            end
            if (mispredict_s && (stat_mis_r != STAT_MAX)) begin
                stat_mis_r <= stat_mis_r + 32'd1;
            end
        end
    end

    assign bp.o_redirect         = redirect_r;
    assign bp.o_redirect_pc      = redirect_pc_r;
    assign bp.o_stat_branches    = stat_br_r;
    assign bp.o_stat_mispredicts = stat_mis_r;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor.
module tb_branch_predictor;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    branch_predictor_if #(.XLEN(32)) bus ();

    branch_predictor #(
        .XLEN(32), .BHT_DEPTH(64), .BTB_DEPTH(16), .INIT_CTR(2'b01)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bp      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] f3;
        logic br, jal, jalr, eq, slt, sltu, pt;
        logic exp_taken, exp_redir;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic [2:0] f3, input logic br, jal, jalr,
                                input logic eq, slt, sltu, pt, et, er);
        vec_t v;
        v.f3 = f3; v.br = br; v.jal = jal; v.jalr = jalr;
        v.eq = eq; v.slt = slt; v.sltu = sltu; v.pt = pt;
        v.exp_taken = et; v.exp_redir = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_res();
        bus.i_res_valid = 1'b0; bus.i_res_pc = 32'd0; bus.i_res_func3 = 3'd0;
        bus.i_res_branch = 1'b0; bus.i_res_jal = 1'b0; bus.i_res_jalr = 1'b0;
        bus.i_res_eq = 1'b0; bus.i_res_slt = 1'b0; bus.i_res_sltu = 1'b0;
        bus.i_res_target = 32'd0; bus.i_res_pred_taken = 1'b0; bus.i_res_pred_target = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_res();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Apply one resolve at the negedge; returns #1 after the capturing edge.
    task automatic resolve(input logic [31:0] pc, input logic [2:0] f3,
                           input logic br, jal, jalr, eq, slt, sltu,
                           input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        @(negedge clk);
        bus.i_res_valid = 1'b1; bus.i_res_pc = pc; bus.i_res_func3 = f3;
        bus.i_res_branch = br; bus.i_res_jal = jal; bus.i_res_jalr = jalr;
        bus.i_res_eq = eq; bus.i_res_slt = slt; bus.i_res_sltu = sltu;
        bus.i_res_target = tgt; bus.i_res_pred_taken = pt; bus.i_res_pred_target = ptgt;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        clear_res();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_fetch(input string name, input logic [31:0] pc,
                             input logic exp_t, input logic [31:0] exp_tgt);
        bus.i_fetch_pc = pc;
        #1;
        check({name, "_taken"}, {31'd0, bus.o_pred_taken}, {31'd0, exp_t});
        check({name, "_target"}, bus.o_pred_target, exp_tgt);
    endtask

    initial begin
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        int          exp_br;
        int          exp_mis;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        bus.i_fetch_pc = 32'd0;
        clear_res();
        #12;
        rst_n = 1'b1;

        // Reset state.
        check("rst_redirect", {31'd0, bus.o_redirect}, 32'd0);
        check("rst_redirect_pc", bus.o_redirect_pc, 32'd0);
        check("rst_stat_br", bus.o_stat_branches, 32'd0);
        check("rst_stat_mis", bus.o_stat_mispredicts, 32'd0);
        chk_fetch("rst_fetch", 32'h100, 1'b0, 32'h104);

        // Taken beq with same-cycle fetch of the same PC: fetch sees old state.
        @(negedge clk);
        bus.i_fetch_pc = 32'h100;
        bus.i_res_valid = 1'b1; bus.i_res_pc = 32'h100; bus.i_res_func3 = 3'b000;
        bus.i_res_branch = 1'b1; bus.i_res_eq = 1'b1; bus.i_res_target = 32'h80;
        bus.i_res_pred_taken = 1'b0; bus.i_res_pred_target = 32'd0;
        #1;
        check("rbw_taken", {31'd0, bus.o_pred_taken}, 32'd0);
        @(posedge clk);
        #1;
        check("beq_redirect", {31'd0, bus.o_redirect}, 32'd1);
        check("beq_redirect_pc", bus.o_redirect_pc, 32'h80);
        chk_fetch("beq_fetch", 32'h100, 1'b1, 32'h80);
        idle();
        check("beq_redirect_pulse", {31'd0, bus.o_redirect}, 32'd0);
        check("beq_stat_br", bus.o_stat_branches, 32'd1);
        check("beq_stat_mis", bus.o_stat_mispredicts, 32'd1);

        // Four taken then not-taken at 0x200: 01->10->11->11->11->10.
        do_reset();
        resolve(32'h200, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h240, 1'b0, 32'd0);
        check("t1_redirect", {31'd0, bus.o_redirect}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            resolve(32'h200, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h240, 1'b1, 32'h240);
            check("tn_redirect", {31'd0, bus.o_redirect}, 32'd0);
        end
        resolve(32'h200, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h240, 1'b0, 32'd0);
        check("nt_redirect", {31'd0, bus.o_redirect}, 32'd0);
        chk_fetch("sat3_fetch", 32'h200, 1'b1, 32'h240);
        check("sat3_stat_br", bus.o_stat_branches, 32'd5);
        check("sat3_stat_mis", bus.o_stat_mispredicts, 32'd1);
        resolve(32'h200, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h240, 1'b1, 32'h240);
        check("nt2_redirect", {31'd0, bus.o_redirect}, 32'd1);
        check("nt2_redirect_pc", bus.o_redirect_pc, 32'h204);
        chk_fetch("nt2_fetch", 32'h200, 1'b0, 32'h204);
        check("nt2_stat_mis", bus.o_stat_mispredicts, 32'd2);

        // Counter floor: 01->00->00, then taken -> 01, still predicts not taken.
        do_reset();
        resolve(32'h100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 32'd0);
        resolve(32'h100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 32'd0);
        resolve(32'h100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'd0);
        chk_fetch("sat0_fetch", 32'h100, 1'b0, 32'h104);

        // Unsigned compares use sltu only.
        do_reset();
        resolve(32'h100, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h180, 1'b0, 32'd0);
        check("bltu_redirect", {31'd0, bus.o_redirect}, 32'd0);
        chk_fetch("bltu_fetch", 32'h100, 1'b0, 32'h104);
        resolve(32'h100, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h180, 1'b0, 32'd0);
        check("bgeu_redirect", {31'd0, bus.o_redirect}, 32'd1);
        check("bgeu_redirect_pc", bus.o_redirect_pc, 32'h180);

        // jalr target change and tag discrimination (0x100 aliases 0x300's index).
        do_reset();
        resolve(32'h300, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h400, 1'b0, 32'd0);
        check("jalr1_redirect", {31'd0, bus.o_redirect}, 32'd1);
        chk_fetch("jalr1_fetch", 32'h300, 1'b1, 32'h400);
        resolve(32'h300, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h500, 1'b1, 32'h400);
        check("jalr2_redirect", {31'd0, bus.o_redirect}, 32'd1);
        check("jalr2_redirect_pc", bus.o_redirect_pc, 32'h500);
        chk_fetch("jalr2_fetch", 32'h300, 1'b1, 32'h500);
        chk_fetch("tag_miss_fetch", 32'h100, 1'b0, 32'h104);

        // Outcome decode table.
        vecs[0]  = mk(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[1]  = mk(3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[3]  = mk(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[5]  = mk(3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[6]  = mk(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[8]  = mk(3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[9]  = mk(3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(3'b011, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[12] = mk(3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        vecs[13] = mk(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        vecs[14] = mk(3'b001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[15] = mk(3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[16] = mk(3'b100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        do_reset();
        exp_br  = 0;
        exp_mis = 0;
        for (int i = 0; i < 17; i++) begin
            tgt = 32'h2000 + 32'(i) * 32'h10;
            resolve(32'h1000, vecs[i].f3, vecs[i].br, vecs[i].jal, vecs[i].jalr,
                    vecs[i].eq, vecs[i].slt, vecs[i].sltu, tgt, vecs[i].pt, tgt);
            if (vecs[i].br || vecs[i].jal || vecs[i].jalr) exp_br++;
            if (vecs[i].exp_redir) exp_mis++;
            check($sformatf("vec%0d_redirect", i), {31'd0, bus.o_redirect}, {31'd0, vecs[i].exp_redir});
            if (vecs[i].exp_redir) begin
                exp_pc = vecs[i].exp_taken ? tgt : 32'h1004;
                check($sformatf("vec%0d_redirect_pc", i), bus.o_redirect_pc, exp_pc);
            end
        end
        idle();
        check("vec_idle_redirect", {31'd0, bus.o_redirect}, 32'd0);
        check("vec_stat_br", bus.o_stat_branches, 32'(exp_br));
        check("vec_stat_mis", bus.o_stat_mispredicts, 32'(exp_mis));

        // Reset while a redirect is pending, then a cold-start update.
        do_reset();
        resolve(32'h100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'd0);
        check("pre_rst_redirect", {31'd0, bus.o_redirect}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_redirect", {31'd0, bus.o_redirect}, 32'd0);
        check("mid_rst_redirect_pc", bus.o_redirect_pc, 32'd0);
        check("mid_rst_stat_br", bus.o_stat_branches, 32'd0);
        chk_fetch("mid_rst_fetch", 32'h100, 1'b0, 32'h104);
        clear_res();
        #1;
        rst_n = 1'b1;
        resolve(32'h100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 1'b0, 32'd0);
        check("cold_nt_redirect", {31'd0, bus.o_redirect}, 32'd0);
        chk_fetch("cold_nt_fetch", 32'h100, 1'b0, 32'h104);
        resolve(32'h100, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h80, 1'b0, 32'd0);
        check("cold_t_redirect", {31'd0, bus.o_redirect}, 32'd1);
        chk_fetch("cold_t_fetch", 32'h100, 1'b0, 32'h104);
        idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
